mac_pe_bist_seq: RTL and testbench
==================================

Name: mac_pe_bist_seq

Overview:
Parametrised successor to the single-shot self-test MAC processing element used in the systolic array.
- Datapath: one weight/input-stationary MAC PE.
- Built-in test: a small on-PE test-vector buffer (up to TV_DEPTH vectors). On one start, every stored vector runs back-to-back through the real multiplier/adder.
- Results: per-run failure count and a sticky fault flag.
- Repair: an optional bypass turns a faulty PE into a register-to-register pass-through, for the array-level BISR controller.

Parameters:
- WORD_SIZE, 16, operand/accumulator width; all arithmetic is modulo 2^WORD_SIZE.
- TV_DEPTH, 4, number of test-vector slots (>=1).
- FAIL_THRESH, 1, minimum failures in one run that set pe_faulty (1..TV_DEPTH).
- CNT_W, $clog2(TV_DEPTH+1), width of tv_count and fail_count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- op2_select_in  in  1  1 = load top_in into the stationary register
- out_select_in  in  1  0 = bottom_out carries top_in_reg; 1 = bottom_out carries accumulator
- stat_bit_in  in  1  1 = multiply by stationary operand, add top_in_reg; 0 = multiply by top_in_reg, add accumulator
- left_in  in  WORD_SIZE  west operand
- top_in  in  WORD_SIZE  north operand
- right_out  out  WORD_SIZE  left_in_reg
- bottom_out  out  WORD_SIZE  per out_select_in / bypass
- tv_wr_en  in  1  append one test vector
- tv_clear  in  1  empty the vector buffer
- tv_mult_op1, tv_mult_op2, tv_add_op, tv_expected  in  WORD_SIZE each  vector fields
- tv_count  out  CNT_W  vectors currently stored
- test_start  in  1  begin a self-test run
- test_busy  out  1  run in progress
- test_done  out  1  one-cycle pulse at end of run
- fail_count  out  CNT_W  mismatches in the last run
- pe_faulty  out  1  sticky fault flag
- bypass_en  in  1  array request to bypass this PE if faulty

Behaviour:
Reset (asynchronous):
- All datapath registers, tv_count, fail_count, test_busy, test_done and pe_faulty go to 0; FSM goes to IDLE.
- Buffer contents are don't-care.

Functional datapath (while test_busy=0):
- left_in_reg and top_in_reg load every cycle.
- accumulator_reg <= adder_out every cycle.
- stationary_reg <= top_in when op2_select_in=1.
- mult = left_in_reg * mux2; adder_out = mult + mux3; both truncated to WORD_SIZE.

Vector buffer:
- tv_clear has priority over tv_wr_en. Both act only in IDLE.
- tv_wr_en writes the slot indexed by tv_count, then tv_count increments.
- A write when tv_count = TV_DEPTH is dropped with no wrap; tv_count holds.
- Writes and clears while busy are ignored.

FSM, states IDLE -> RUN -> DONE -> IDLE:
- IDLE: test_start sampled high moves to RUN. At the same edge: idx <= 0, fail_count <= 0, test_busy <= 1.
- IDLE with tv_count = 0: test_start moves straight to DONE, with fail_count = 0 and pe_faulty unchanged.
- RUN: each cycle, adder_out = tv_mult_op1[idx] * tv_mult_op2[idx] + tv_add_op[idx].
  - At the edge, on mismatch with tv_expected[idx], fail_count increments.
  - idx increments; after idx = tv_count-1, go to DONE.
  - N vectors take exactly N RUN cycles.
- DONE: test_done = 1 and test_busy = 0 for exactly one cycle, then IDLE.
  - pe_faulty sets at the RUN->DONE edge if the final fail_count >= FAIL_THRESH.
  - fail_count holds until the next start.
- Latency: start at edge k gives test_done high in cycle k+N+1, where N = tv_count (N=0 gives cycle k+1).
- test_start while not IDLE is ignored.

Freeze during test_busy:
- left_in_reg, top_in_reg, accumulator_reg and stationary_reg hold; op2_select_in is ignored.
- Functional operation resumes with the pre-test state.
- Upstream must hold inputs stable across the run.

pe_faulty:
- Sticky; cleared only by rst.
- A later passing run does not clear it.

Bypass:
- Active when pe_faulty & bypass_en: right_out = left_in_reg, bottom_out = top_in_reg regardless of out_select_in, and the accumulator holds.
- With bypass_en=1 and pe_faulty=0, behaviour is normal.

Reset mid-run aborts the run with no done pulse.

Decomposition:
- Shared package (pe_bist_pkg): FSM state encoding (IDLE=0, RUN=1, DONE=2) and the CNT_W derivation function.
- One sub-module, pe_tv_buffer: the TV_DEPTH x 4·WORD_SIZE register file with the write pointer/tv_count and an async read port indexed by idx.
- FSM, compare logic and datapath stay in the top module.

Test Plan:
1. Functional WS: load stationary 3; with stat_bit_in=1, left_in 2,4,5 and top_in 0,6,7 -> accumulator/bottom_out sequence 6, 18, 22.
2. Pass run: write vectors (3,4,5,17), (2,2,0,4), (0xFFFF,2,0,0xFFFE), then start -> tv_count=3, test_busy high for 3 cycles, test_done in cycle k+4, fail_count=0, pe_faulty=0.
3. Fail run: change vector 2's expected value to 5 and FAIL_THRESH=1 -> fail_count=1, pe_faulty=1. A subsequent passing run leaves pe_faulty=1.
4. Freeze/resume: mid-accumulation with accumulator=18, start a 2-vector run while driving new left_in/top_in -> accumulator stays 18 during test_busy, and the next functional cycle adds the held operands.
5. Bypass: pe_faulty=1 and bypass_en=1, left_in=0xA5, top_in=0x3C -> one cycle later right_out=0xA5, bottom_out=0x3C, accumulator unchanged.
6. Boundaries:
   - TV_DEPTH+1 writes -> tv_count=TV_DEPTH.
   - Start with an empty buffer -> test_done next cycle, fail_count=0.
   - test_start during RUN -> ignored.
   - rst mid-RUN -> all outputs 0, no test_done pulse.

Source files
------------

// File: rtl/mac_pe_bist_seq_pkg.sv
// Shared definitions for the self-testing MAC PE.
// Contains the BIST FSM state encoding and the counter-width helper.
package pe_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    // Counters must represent the full depth, not just the last slot index.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mac_pe_bist_seq_tv_buffer.sv
// Append-only test-vector register file with an occupancy count.
// Reads are asynchronous and indexed by the BIST sequencer.
module pe_tv_buffer
    import pe_bist_pkg::*;
#(
    parameter int TV_DEPTH = 4,
    parameter int TV_W     = 64,
    parameter int CNT_W    = cnt_width(TV_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             clear,
    input  logic [TV_W-1:0]  wr_data,
    input  logic [CNT_W-1:0] rd_idx,
    output logic [TV_W-1:0]  rd_data,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TV_DEPTH);

    logic [TV_W-1:0]  mem_q [TV_DEPTH];
    logic [TV_W-1:0]  mem_d [TV_DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A full buffer silently drops further appends rather than wrapping.
    always_comb begin
        count_d = count_q;
        mem_d   = mem_q;
        if (clear) begin
            count_d = '0;
        end else if (wr_en && (count_q < DEPTH_C)) begin
            for (int i = 0; i < TV_DEPTH; i++) begin
                if (count_q == CNT_W'(i)) begin
                    mem_d[i] = wr_data;
                end
            end
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < TV_DEPTH; i++) begin
            if (rd_idx == CNT_W'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mac_pe_bist_seq.sv
// Weight/input-stationary MAC PE with an on-PE vector self-test that reuses the
// real multiplier/adder, a sticky fault flag and a bypass path for array repair.
module mac_pe_bist_seq
    import pe_bist_pkg::*;
#(
    parameter int WORD_SIZE   = 16,
    parameter int TV_DEPTH    = 4,
    parameter int FAIL_THRESH = 1,
    parameter int CNT_W       = cnt_width(TV_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op2_select_in,
    input  logic                 out_select_in,
    input  logic                 stat_bit_in,
    input  logic [WORD_SIZE-1:0] left_in,
    input  logic [WORD_SIZE-1:0] top_in,
    output logic [WORD_SIZE-1:0] right_out,
    output logic [WORD_SIZE-1:0] bottom_out,
    input  logic                 tv_wr_en,
    input  logic                 tv_clear,
    input  logic [WORD_SIZE-1:0] tv_mult_op1,
    input  logic [WORD_SIZE-1:0] tv_mult_op2,
    input  logic [WORD_SIZE-1:0] tv_add_op,
    input  logic [WORD_SIZE-1:0] tv_expected,
    output logic [CNT_W-1:0]     tv_count,
    input  logic                 test_start,
    output logic                 test_busy,
    output logic                 test_done,
    output logic [CNT_W-1:0]     fail_count,
    output logic                 pe_faulty,
    input  logic                 bypass_en
);
    localparam int               TV_W     = 4 * WORD_SIZE;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(FAIL_THRESH);

    bist_state_t          state_q, state_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     fail_count_q, fail_count_d;
    logic                 pe_faulty_q, pe_faulty_d;

    logic [WORD_SIZE-1:0] left_in_reg_q, left_in_reg_d;
    logic [WORD_SIZE-1:0] top_in_reg_q, top_in_reg_d;
    logic [WORD_SIZE-1:0] accumulator_q, accumulator_d;
    logic [WORD_SIZE-1:0] stationary_q, stationary_d;

    logic [TV_W-1:0]      tv_wr_data, tv_rd_data;
    logic [WORD_SIZE-1:0] tv_op1, tv_op2, tv_add, tv_exp;
    logic                 buf_wr_en, buf_clear;

    logic [WORD_SIZE-1:0] mux2, mux3, mult_a, mult_b, add_b, mult, adder_out;
    logic                 mismatch, last_vec, bypass_active;

    assign tv_wr_data = {tv_mult_op1, tv_mult_op2, tv_add_op, tv_expected};
    assign {tv_op1, tv_op2, tv_add, tv_exp} = tv_rd_data;

    pe_tv_buffer #(
        .TV_DEPTH (TV_DEPTH),
        .TV_W     (TV_W),
        .CNT_W    (CNT_W)
    ) u_tv_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_wr_en),
        .clear   (buf_clear),
        .wr_data (tv_wr_data),
        .rd_idx  (idx_q),
        .rd_data (tv_rd_data),
        .count   (tv_count)
    );

    assign last_vec      = ((idx_q + CNT_W'(1)) == tv_count);
    assign bypass_active = pe_faulty_q & bypass_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            fail_count_q <= '0;
            pe_faulty_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            fail_count_q <= fail_count_d;
            pe_faulty_q  <= pe_faulty_d;
        end
    end

    // An empty buffer skips RUN so the done pulse still follows one cycle after start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (test_start) state_d = (tv_count == '0) ? DONE : RUN;
            RUN:     if (last_vec) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        test_busy = (state_q == RUN);
        test_done = (state_q == DONE);
        buf_wr_en = (state_q == IDLE) && tv_wr_en;
        buf_clear = (state_q == IDLE) && tv_clear;
    end

    // The fault decision uses the count including the final vector's result.
    always_comb begin
        idx_d        = idx_q;
        fail_count_d = fail_count_q;
        pe_faulty_d  = pe_faulty_q;
        if ((state_q == IDLE) && test_start) begin
            idx_d        = '0;
            fail_count_d = '0;
        end else if (state_q == RUN) begin
            idx_d = idx_q + CNT_W'(1);
            if (mismatch) begin
                fail_count_d = fail_count_q + CNT_W'(1);
            end
            if (last_vec && (fail_count_d >= THRESH_C)) begin
                pe_faulty_d = 1'b1;
            end
        end
    end

    // The test steers vectors through the same multiplier/adder used functionally.
    always_comb begin
        mux2   = stat_bit_in ? stationary_q : top_in_reg_q;
        mux3   = stat_bit_in ? top_in_reg_q : accumulator_q;
        mult_a = left_in_reg_q;
        mult_b = mux2;
        add_b  = mux3;
        if (state_q == RUN) begin
            mult_a = tv_op1;
            mult_b = tv_op2;
            add_b  = tv_add;
        end
        mult      = mult_a * mult_b;
        adder_out = mult + add_b;
        mismatch  = (adder_out != tv_exp);
    end

    always_comb begin
        left_in_reg_d = left_in_reg_q;
        top_in_reg_d  = top_in_reg_q;
        accumulator_d = accumulator_q;
        stationary_d  = stationary_q;
        if (!test_busy) begin
            left_in_reg_d = left_in;
            top_in_reg_d  = top_in;
            if (!bypass_active) begin
                accumulator_d = adder_out;
            end
            if (op2_select_in) begin
                stationary_d = top_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_in_reg_q <= '0;
            top_in_reg_q  <= '0;
            accumulator_q <= '0;
            stationary_q  <= '0;
        end else begin
            left_in_reg_q <= left_in_reg_d;
            top_in_reg_q  <= top_in_reg_d;
            accumulator_q <= accumulator_d;
            stationary_q  <= stationary_d;
        end
    end

    assign right_out  = left_in_reg_q;
    assign bottom_out = (bypass_active || !out_select_in) ? top_in_reg_q : accumulator_q;
    assign fail_count = fail_count_q;
    assign pe_faulty  = pe_faulty_q;

endmodule

// File: tb/tb_mac_pe_bist_seq.sv
// Self-checking bench for mac_pe_bist_seq: a cycle-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mac_pe_bist_seq;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int THR   = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          op2_select_in = 1'b0, out_select_in = 1'b0, stat_bit_in = 1'b0;
    logic [W-1:0]  left_in = '0, top_in = '0;
    logic [W-1:0]  right_out, bottom_out;
    logic          tv_wr_en = 1'b0, tv_clear = 1'b0;
    logic [W-1:0]  tv_mult_op1 = '0, tv_mult_op2 = '0, tv_add_op = '0, tv_expected = '0;
    logic [2:0]    tv_count;
    logic          test_start = 1'b0;
    logic          test_busy, test_done;
    logic [2:0]    fail_count;
    logic          pe_faulty;
    logic          bypass_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    mac_pe_bist_seq #(
        .WORD_SIZE   (W),
        .TV_DEPTH    (DEPTH),
        .FAIL_THRESH (THR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .op2_select_in (op2_select_in),
        .out_select_in (out_select_in),
        .stat_bit_in   (stat_bit_in),
        .left_in       (left_in),
        .top_in        (top_in),
        .right_out     (right_out),
        .bottom_out    (bottom_out),
        .tv_wr_en      (tv_wr_en),
        .tv_clear      (tv_clear),
        .tv_mult_op1   (tv_mult_op1),
        .tv_mult_op2   (tv_mult_op2),
        .tv_add_op     (tv_add_op),
        .tv_expected   (tv_expected),
        .tv_count      (tv_count),
        .test_start    (test_start),
        .test_busy     (test_busy),
        .test_done     (test_done),
        .fail_count    (fail_count),
        .pe_faulty     (pe_faulty),
        .bypass_en     (bypass_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] e;
    } vec_t;

    // Reference model state.
    vec_t         m_vecs[$];
    logic [W-1:0] m_left = '0, m_top = '0, m_acc = '0, m_stat = '0;
    bit           m_busy = 1'b0, m_done = 1'b0, m_faulty = 1'b0;
    int           m_fail = 0;
    int           run_pos = 0;

    function automatic bit vecFails(input vec_t v);
        logic [31:0] full;
        full = {16'b0, v.a} * {16'b0, v.b} + {16'b0, v.c};
        return (full[15:0] != v.e);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a frozen datapath while a run is active; otherwise a registered MAC.
    always @(posedge clk or posedge rst) begin
        logic [W-1:0] sum;
        if (rst) begin
            m_vecs.delete();
            m_left = '0; m_top = '0; m_acc = '0; m_stat = '0;
            m_busy = 1'b0; m_done = 1'b0; m_faulty = 1'b0;
            m_fail = 0; run_pos = 0;
        end else begin
            if (!m_busy) begin
                sum = m_left * (stat_bit_in ? m_stat : m_top) + (stat_bit_in ? m_top : m_acc);
                if (!(m_faulty && bypass_en)) m_acc = sum;
                m_left = left_in;
                m_top  = top_in;
                if (op2_select_in) m_stat = top_in;
            end
            if (m_busy) begin
                if (vecFails(m_vecs[run_pos])) m_fail++;
                run_pos++;
                if (run_pos == m_vecs.size()) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    if (m_fail >= THR) m_faulty = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else begin
                if (test_start) begin
                    m_fail  = 0;
                    run_pos = 0;
                    if (m_vecs.size() == 0) m_done = 1'b1;
                    else m_busy = 1'b1;
                end
                if (tv_clear) m_vecs.delete();
                else if (tv_wr_en && m_vecs.size() < DEPTH)
                    m_vecs.push_back('{tv_mult_op1, tv_mult_op2, tv_add_op, tv_expected});
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (check_en) begin
            checkOutput("model_right_out", 32'(right_out), 32'(m_left));
            checkOutput("model_bottom_out", 32'(bottom_out),
                        32'(((m_faulty && bypass_en) || !out_select_in) ? m_top : m_acc));
            checkOutput("model_tv_count", 32'(tv_count), 32'(m_vecs.size()));
            checkOutput("model_test_busy", 32'(test_busy), 32'(m_busy));
            checkOutput("model_test_done", 32'(test_done), 32'(m_done));
            checkOutput("model_fail_count", 32'(fail_count), 32'(m_fail));
            checkOutput("model_pe_faulty", 32'(pe_faulty), 32'(m_faulty));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [W-1:0] l, input logic [W-1:0] t,
                                 input logic op2, input logic stat, input logic osel);
        left_in = l; top_in = t;
        op2_select_in = op2; stat_bit_in = stat; out_select_in = osel;
        step();
    endtask

    task automatic writeVector(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] c, input logic [W-1:0] e);
        tv_wr_en = 1'b1;
        tv_mult_op1 = a; tv_mult_op2 = b; tv_add_op = c; tv_expected = e;
        step();
        tv_wr_en = 1'b0;
    endtask

    task automatic clearBuffer();
        tv_clear = 1'b1;
        step();
        tv_clear = 1'b0;
    endtask

    task automatic runTest(input string tag, input int exp_n, input int exp_fail,
                           input bit exp_faulty, input bit poke);
        int n_busy;
        int done_at;
        n_busy  = 0;
        done_at = -1;
        test_start = 1'b1;
        step();
        test_start = 1'b0;
        for (int c = 0; c < 32; c++) begin
            if (test_done) begin
                done_at = c;
                break;
            end
            if (test_busy) n_busy++;
            test_start = poke && (c == 0);
            step();
        end
        test_start = 1'b0;
        checkOutput({tag, "_done_latency"}, 32'(done_at), 32'(exp_n));
        checkOutput({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_n));
        checkOutput({tag, "_fail_count"}, 32'(fail_count), 32'(exp_fail));
        checkOutput({tag, "_pe_faulty"}, 32'(pe_faulty), 32'(exp_faulty));
        step();
        checkOutput({tag, "_done_width"}, 32'(test_done), 32'(0));
        checkOutput({tag, "_idle_after"}, 32'(test_busy), 32'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] acc_before;

        @(negedge clk);
        rst = 1'b1;
        check_en = 1'b1;
        step();
        checkOutput("reset_right_out", 32'(right_out), 32'(0));
        checkOutput("reset_bottom_out", 32'(bottom_out), 32'(0));
        checkOutput("reset_tv_count", 32'(tv_count), 32'(0));
        checkOutput("reset_busy", 32'(test_busy), 32'(0));
        checkOutput("reset_done", 32'(test_done), 32'(0));
        checkOutput("reset_faulty", 32'(pe_faulty), 32'(0));
        rst = 1'b0;
        step();

        $display("[TB] functional weight-stationary accumulate");
        applyStimulus(16'd0, 16'd3, 1'b1, 1'b1, 1'b1);
        applyStimulus(16'd2, 16'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(16'd4, 16'd6, 1'b0, 1'b1, 1'b1);
        checkOutput("ws_acc_1", 32'(bottom_out), 32'd6);
        applyStimulus(16'd5, 16'd7, 1'b0, 1'b1, 1'b1);
        checkOutput("ws_acc_2", 32'(bottom_out), 32'd18);
        applyStimulus(16'd5, 16'd7, 1'b0, 1'b1, 1'b1);
        checkOutput("ws_acc_3", 32'(bottom_out), 32'd22);
        checkOutput("ws_right_out", 32'(right_out), 32'd5);

        $display("[TB] freeze and resume around a two-vector run");
        clearBuffer();
        writeVector(16'd3, 16'd4, 16'd5, 16'd17);
        writeVector(16'd2, 16'd2, 16'd0, 16'd4);
        applyStimulus(16'd2, 16'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(16'd4, 16'd6, 1'b0, 1'b1, 1'b1);
        left_in = 16'd9; top_in = 16'd1; test_start = 1'b1;
        step();
        test_start = 1'b0;
        checkOutput("frz_acc_run0", 32'(bottom_out), 32'd18);
        checkOutput("frz_busy_run0", 32'(test_busy), 32'd1);
        left_in = 16'd11; top_in = 16'd13;
        step();
        checkOutput("frz_acc_run1", 32'(bottom_out), 32'd18);
        checkOutput("frz_right_run1", 32'(right_out), 32'd9);
        step();
        checkOutput("frz_done", 32'(test_done), 32'd1);
        checkOutput("frz_acc_done", 32'(bottom_out), 32'd18);
        step();
        checkOutput("frz_resume_acc", 32'(bottom_out), 32'd28);
        checkOutput("frz_resume_right", 32'(right_out), 32'd11);

        $display("[TB] passing run with a start pulse during RUN");
        clearBuffer();
        writeVector(16'd3, 16'd4, 16'd5, 16'd17);
        writeVector(16'd2, 16'd2, 16'd0, 16'd4);
        writeVector(16'hFFFF, 16'd2, 16'd0, 16'hFFFE);
        checkOutput("pass_tv_count", 32'(tv_count), 32'd3);
        runTest("pass", 3, 0, 1'b0, 1'b1);

        $display("[TB] failing run");
        clearBuffer();
        writeVector(16'd3, 16'd4, 16'd5, 16'd17);
        writeVector(16'd2, 16'd2, 16'd0, 16'd5);
        writeVector(16'hFFFF, 16'd2, 16'd0, 16'hFFFE);
        runTest("fail", 3, 1, 1'b1, 1'b0);

        $display("[TB] empty-buffer run");
        clearBuffer();
        checkOutput("empty_tv_count", 32'(tv_count), 32'd0);
        runTest("empty", 0, 0, 1'b1, 1'b0);

        $display("[TB] overflow writes then sticky fault on a passing run");
        writeVector(16'd3, 16'd4, 16'd5, 16'd17);
        writeVector(16'd2, 16'd2, 16'd0, 16'd4);
        writeVector(16'hFFFF, 16'd2, 16'd0, 16'hFFFE);
        writeVector(16'd7, 16'd7, 16'd1, 16'd50);
        writeVector(16'd1, 16'd1, 16'd1, 16'd9);
        checkOutput("ovf_tv_count", 32'(tv_count), 32'd4);
        runTest("sticky", 4, 0, 1'b1, 1'b0);

        $display("[TB] bypass of a faulty PE");
        acc_before = m_acc;
        bypass_en = 1'b1;
        applyStimulus(16'h00A5, 16'h003C, 1'b0, 1'b1, 1'b1);
        checkOutput("byp_right_out", 32'(right_out), 32'h00A5);
        checkOutput("byp_bottom_out", 32'(bottom_out), 32'h003C);
        applyStimulus(16'h00A5, 16'h003C, 1'b0, 1'b1, 1'b1);
        checkOutput("byp_bottom_hold", 32'(bottom_out), 32'h003C);
        bypass_en = 1'b0;
        #1;
        checkOutput("byp_acc_unchanged", 32'(bottom_out), 32'(acc_before));
        @(negedge clk);

        $display("[TB] reset during RUN");
        test_start = 1'b1;
        step();
        test_start = 1'b0;
        step();
        checkOutput("rst_run_busy", 32'(test_busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_run_right", 32'(right_out), 32'd0);
        checkOutput("rst_run_bottom", 32'(bottom_out), 32'd0);
        checkOutput("rst_run_count", 32'(tv_count), 32'd0);
        checkOutput("rst_run_fails", 32'(fail_count), 32'd0);
        checkOutput("rst_run_faulty", 32'(pe_faulty), 32'd0);
        @(negedge clk);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("rst_run_no_done", 32'(test_done), 32'd0);
            checkOutput("rst_run_no_busy", 32'(test_busy), 32'd0);
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
